// File: rtl/ttt_key_pkg.sv
// ttt_key_pkg: shared definitions for the tic-tac-toe console key receive path.
// Holds the byte codes the decoder recognises, the receiver and decoder state
// encodings, the key strobe bundle and two small byte-to-key lookup helpers.
package ttt_key_pkg;

  // Control and escape bytes
  localparam logic [7:0] KEY_ESC   = 8'h1B;
  localparam logic [7:0] KEY_CSI   = 8'h5B;  // '[' after ESC
  localparam logic [7:0] KEY_CR    = 8'h0D;
  localparam logic [7:0] KEY_LF    = 8'h0A;
  localparam logic [7:0] KEY_SPACE = 8'h20;

  // WASD letters, both cases
  localparam logic [7:0] KEY_W_LO = 8'h77;
  localparam logic [7:0] KEY_W_UP = 8'h57;
  localparam logic [7:0] KEY_A_LO = 8'h61;
  localparam logic [7:0] KEY_A_UP = 8'h41;
  localparam logic [7:0] KEY_S_LO = 8'h73;
  localparam logic [7:0] KEY_S_UP = 8'h53;
  localparam logic [7:0] KEY_D_LO = 8'h64;
  localparam logic [7:0] KEY_D_UP = 8'h44;

  // Final bytes of the ANSI cursor sequences ESC [ A..D
  localparam logic [7:0] KEY_ARROW_UP    = 8'h41;
  localparam logic [7:0] KEY_ARROW_DOWN  = 8'h42;
  localparam logic [7:0] KEY_ARROW_RIGHT = 8'h43;
  localparam logic [7:0] KEY_ARROW_LEFT  = 8'h44;

  typedef enum logic [2:0] {
    RxArm,
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  typedef enum logic [1:0] {
    DIdle,
    DEsc,
    DCsi
  } dec_state_e;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic enter;
    logic space;
  } key_strobe_t;

  // Mapping for a byte seen outside any escape sequence.
  function automatic key_strobe_t plain_key(input logic [7:0] b);
    key_strobe_t k;
    k = '0;
    case (b)
      KEY_W_LO, KEY_W_UP: k.up    = 1'b1;
      KEY_S_LO, KEY_S_UP: k.down  = 1'b1;
      KEY_A_LO, KEY_A_UP: k.left  = 1'b1;
      KEY_D_LO, KEY_D_UP: k.right = 1'b1;
      KEY_CR, KEY_LF:     k.enter = 1'b1;
      KEY_SPACE:          k.space = 1'b1;
      default:            k = '0;
    endcase
    return k;
  endfunction

  // Mapping for the byte that terminates ESC [.
  function automatic key_strobe_t csi_key(input logic [7:0] b);
    key_strobe_t k;
    k = '0;
    case (b)
      KEY_ARROW_UP:    k.up    = 1'b1;
      KEY_ARROW_DOWN:  k.down  = 1'b1;
      KEY_ARROW_RIGHT: k.right = 1'b1;
      KEY_ARROW_LEFT:  k.left  = 1'b1;
      default:         k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 2-FF synchroniser plus 8N1 receiver FSM.
// Ports:
//   clk        in   game-logic clock
//   reset      in   synchronous active-high reset
//   rx_in      in   asynchronous UART line, idles high
//   byte_valid out  one-cycle strobe, byte_data holds a good byte
//   byte_data  out  last received byte, LSB first on the wire
//   frame_err  out  one-cycle strobe, stop bit sampled low (byte dropped)
module uart_rx_byte
  import ttt_key_pkg::*;
#(
  parameter int unsigned CPB = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned HALF   = CPB / 2;
  localparam int unsigned CntW   = $clog2(CPB + 1);
  // Cycles the synced line must read high before a start bit is accepted.
  // Covers the synchroniser depth so its reset value of 1 cannot fake an idle line.
  localparam int unsigned ArmCyc = 3;

  logic [1:0]    sync_q;
  rx_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          done_q, done_d;
  logic          stop_q, stop_d;
  logic          byte_valid_q;
  logic          frame_err_q;
  logic          line;

  assign line = sync_q[1];

  // cnt_q counts cycles since the synced falling edge in START, and cycles since
  // the previous sample in DATA/STOP, so the sample points land at HALF + n*CPB.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    stop_d  = stop_q;
    unique case (state_q)
      RxArm: begin
        if (!line) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(ArmCyc - 1)) begin
          state_d = RxIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxIdle: begin
        if (!line) begin
          state_d = RxStart;
          cnt_d   = CntW'(2);
        end
      end
      RxStart: begin
        if (cnt_q == CntW'(HALF)) begin
          if (line) begin
            state_d = RxIdle;
          end else begin
            state_d = RxData;
            cnt_d   = CntW'(1);
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (cnt_q == CntW'(CPB)) begin
          shift_d = {line, shift_q[7:1]};
          cnt_d   = CntW'(1);
          if (bit_q == 3'd7) begin
            state_d = RxStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_q == CntW'(CPB)) begin
          done_d  = 1'b1;
          stop_d  = line;
          state_d = RxArm;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RxArm;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= 2'b11;
      state_q      <= RxArm;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      done_q       <= 1'b0;
      stop_q       <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], rx_in};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      done_q       <= done_d;
      stop_q       <= stop_d;
      byte_valid_q <= done_q & stop_q;
      frame_err_q  <= done_q & ~stop_q;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_key_decoder.sv
// uart_key_decoder: turns host-terminal UART bytes into single-cycle key strobes
// for the game controller. WASD, Enter (CR/LF), Space and ESC [ A..D arrows.
// Ports:
//   clk        in   25 MHz game-logic clock
//   reset      in   synchronous active-high reset
//   rx_in      in   asynchronous UART line, idles high
//   up/down/left/right  out  one-cycle cursor-move strobes
//   enter      out  one-cycle place-mark strobe
//   space      out  one-cycle restart/skip strobe
//   frame_err  out  one-cycle strobe on a low stop bit
module uart_key_decoder
  import ttt_key_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 25_000_000,
  parameter int unsigned BAUD            = 115200,
  parameter int unsigned ESC_TIMEOUT_CYC = 250_000
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_in,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic enter,
  output logic space,
  output logic frame_err
);

  localparam int unsigned CPB  = CLK_HZ / BAUD;
  localparam int unsigned TmoW = $clog2(ESC_TIMEOUT_CYC + 1);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       rx_frame_err;

  uart_rx_byte #(
    .CPB(CPB)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (rx_frame_err)
  );

  dec_state_e      dec_q, dec_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  key_strobe_t     key_q, key_d;
  logic            ferr_q;

  // A byte takes priority over timeout expiry and is decoded in the current state.
  always_comb begin
    dec_d = dec_q;
    tmo_d = tmo_q;
    key_d = '0;
    if (byte_valid) begin
      unique case (dec_q)
        DIdle: begin
          if (byte_data == KEY_ESC) begin
            dec_d = DEsc;
          end else begin
            key_d = plain_key(byte_data);
          end
        end
        DEsc: begin
          if (byte_data == KEY_CSI) begin
            dec_d = DCsi;
          end else if (byte_data == KEY_ESC) begin
            dec_d = DEsc;
          end else begin
            // Lone ESC followed by a normal key: treat the key as if no ESC came.
            dec_d = DIdle;
            key_d = plain_key(byte_data);
          end
        end
        DCsi: begin
          dec_d = DIdle;
          key_d = csi_key(byte_data);
        end
        default: dec_d = DIdle;
      endcase
      if (dec_d != DIdle) begin
        tmo_d = TmoW'(ESC_TIMEOUT_CYC);
      end
    end else if (dec_q != DIdle) begin
      if (tmo_q == '0) begin
        dec_d = DIdle;
      end else begin
        tmo_d = tmo_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q  <= DIdle;
      tmo_q  <= '0;
      key_q  <= '0;
      ferr_q <= 1'b0;
    end else begin
      dec_q  <= dec_d;
      tmo_q  <= tmo_d;
      key_q  <= key_d;
      ferr_q <= rx_frame_err;
    end
  end

  assign up        = key_q.up;
  assign down      = key_q.down;
  assign left      = key_q.left;
  assign right     = key_q.right;
  assign enter     = key_q.enter;
  assign space     = key_q.space;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_key_decoder.sv
// tb_uart_key_decoder: directed UART frames into uart_key_decoder, checked every
// cycle against a byte-level behavioural model of the key decoding rules.
module tb_uart_key_decoder;

  localparam int unsigned CLK_HZ = 25_000_000;
  localparam int unsigned BAUD   = 115200;
  localparam int unsigned TMO    = 20_000;  // shortened escape timeout
  localparam int unsigned CPB    = CLK_HZ / BAUD;
  localparam int unsigned HALF   = CPB / 2;
  // Rx edge to strobe: synchroniser, stop-bit sample, byte_valid, strobe register.
  localparam int LAT = 2 + HALF + 9 * CPB + 2;

  localparam logic [6:0] V_UP    = 7'b1000000;
  localparam logic [6:0] V_DOWN  = 7'b0100000;
  localparam logic [6:0] V_LEFT  = 7'b0010000;
  localparam logic [6:0] V_RIGHT = 7'b0001000;
  localparam logic [6:0] V_ENTER = 7'b0000100;
  localparam logic [6:0] V_SPACE = 7'b0000010;
  localparam logic [6:0] V_FERR  = 7'b0000001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_in = 1'b1;
  logic up, down, left, right, enter, space, frame_err;
  logic [6:0] dut_vec;

  uart_key_decoder #(
    .CLK_HZ         (CLK_HZ),
    .BAUD           (BAUD),
    .ESC_TIMEOUT_CYC(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_in    (rx_in),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .enter    (enter),
    .space    (space),
    .frame_err(frame_err)
  );

  assign dut_vec = {up, down, left, right, enter, space, frame_err};

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [6:0] vec;
  } ev_t;

  ev_t exp_q[$];
  ev_t seen_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  last_start = 0;

  // Model state: 0 plain, 1 after ESC, 2 after ESC [
  int m_st = 0;
  int m_last_bv = 0;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, got, got, want, want, cyc);
    end
  endtask

  function automatic logic [6:0] plain_vec(input logic [7:0] b);
    case (b)
      8'h77, 8'h57: return V_UP;
      8'h73, 8'h53: return V_DOWN;
      8'h61, 8'h41: return V_LEFT;
      8'h64, 8'h44: return V_RIGHT;
      8'h0D, 8'h0A: return V_ENTER;
      8'h20:        return V_SPACE;
      default:      return 7'b0;
    endcase
  endfunction

  function automatic logic [6:0] arrow_vec(input logic [7:0] b);
    case (b)
      8'h41:   return V_UP;
      8'h42:   return V_DOWN;
      8'h43:   return V_RIGHT;
      8'h44:   return V_LEFT;
      default: return 7'b0;
    endcase
  endfunction

  // Predict the strobe caused by one complete frame starting at cycle c0.
  task automatic model_byte(input logic [7:0] b, input logic stop_bit, input int c0);
    int         bv;
    logic [6:0] vec;
    bv  = c0 + LAT - 1;
    vec = '0;
    if (!stop_bit) begin
      exp_q.push_back('{c0 + LAT, V_FERR});
    end else begin
      // An escape sequence left pending longer than the timeout has been dropped.
      if (m_st != 0 && (bv - m_last_bv) > int'(TMO) + 1) m_st = 0;
      case (m_st)
        0: if (b == 8'h1B) m_st = 1; else vec = plain_vec(b);
        1: begin
          if (b == 8'h5B) m_st = 2;
          else if (b != 8'h1B) begin
            m_st = 0;
            vec  = plain_vec(b);
          end
        end
        default: begin
          m_st = 0;
          vec  = arrow_vec(b);
        end
      endcase
      m_last_bv = bv;
      if (vec != 0) exp_q.push_back('{c0 + LAT, vec});
    end
  endtask

  // Drive the first nbits of a frame (start, 8 data LSB first, stop).
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int nbits);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    @(posedge clk);
    #1;
    last_start = cyc;
    if (nbits == 10) model_byte(b, stop_bit, cyc);
    for (int i = 0; i < nbits; i++) begin
      rx_in = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic line, input int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    rx_in = line;
    exp_q.delete();
    m_st = 0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Exactly one observed event, with the given strobe and offset from last_start.
  task automatic check_single(input string name, input logic [6:0] vec, input int offset);
    check({name, "_count"}, seen_q.size(), 1);
    if (seen_q.size() != 0) begin
      check({name, "_vec"}, int'(seen_q[0].vec), int'(vec));
      check({name, "_latency"}, seen_q[0].cyc - last_start, offset);
    end
    seen_q.delete();
  endtask

  // Per-cycle compare against the model.
  initial begin
    logic [6:0] want;
    forever begin
      @(negedge clk);
      want = '0;
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        check("missed_strobe", 0, int'(exp_q[0].vec));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        want = exp_q[0].vec;
        void'(exp_q.pop_front());
      end
      check("strobes", int'(dut_vec), int'(want));
      check("onehot_keys", int'($onehot0(dut_vec[6:1])), 1);
      if (dut_vec != 0) seen_q.push_back('{cyc, dut_vec});
    end
  end

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check("reset_state", int'(dut_vec), 0);
    reset = 1'b0;
    idle(20);

    // Plain 'w'
    seen_q.delete();
    send_byte(8'h77, 1'b1, 10);
    idle(20);
    check_single("w_up", V_UP, 2065);

    // ESC [ C back to back
    send_byte(8'h1B, 1'b1, 10);
    send_byte(8'h5B, 1'b1, 10);
    send_byte(8'h43, 1'b1, 10);
    idle(20);
    check_single("csi_right", V_RIGHT, 2065);

    // ESC, gap beyond timeout, 'a'
    send_byte(8'h1B, 1'b1, 10);
    idle(TMO + 4000);
    send_byte(8'h61, 1'b1, 10);
    idle(20);
    check_single("esc_timeout_left", V_LEFT, 2065);

    // ESC, short gap, 'a' reprocessed
    send_byte(8'h1B, 1'b1, 10);
    idle(1000);
    send_byte(8'h61, 1'b1, 10);
    idle(20);
    check_single("esc_reprocess_left", V_LEFT, 2065);

    // Space with bad stop bit, then CR
    send_byte(8'h20, 1'b0, 10);
    idle(20);
    check_single("frame_err", V_FERR, 2065);
    send_byte(8'h0D, 1'b1, 10);
    idle(20);
    check_single("cr_enter", V_ENTER, 2065);

    // 50-cycle glitch, then 'd'
    @(posedge clk);
    #1;
    rx_in = 1'b0;
    idle(50);
    rx_in = 1'b1;
    idle(400);
    check("glitch_silent", seen_q.size(), 0);
    send_byte(8'h64, 1'b1, 10);
    idle(20);
    check_single("d_right", V_RIGHT, 2065);

    // Line held low across reset release
    do_reset(1'b0, 4);
    seen_q.delete();
    idle(5000);
    check("held_low_silent", seen_q.size(), 0);
    rx_in = 1'b1;
    idle(20);
    send_byte(8'h73, 1'b1, 10);
    idle(20);
    check_single("s_down", V_DOWN, 2065);

    // Reset mid-frame, then a full 'W'
    send_byte(8'h77, 1'b1, 5);
    do_reset(1'b1, 3);
    idle(3 * CPB);
    check("abort_silent", seen_q.size(), 0);
    send_byte(8'h57, 1'b1, 10);
    idle(20);
    check_single("upper_w_up", V_UP, 2065);

    // ESC ESC [ D, then LF
    send_byte(8'h1B, 1'b1, 10);
    send_byte(8'h1B, 1'b1, 10);
    send_byte(8'h5B, 1'b1, 10);
    send_byte(8'h44, 1'b1, 10);
    idle(20);
    check_single("esc_esc_left", V_LEFT, 2065);
    send_byte(8'h0A, 1'b1, 10);
    idle(20);
    check_single("lf_enter", V_ENTER, 2065);

    idle(50);
    check("pending_expectations", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
